// File: rtl/is_uart_rx_fifo.sv
// Receive buffer behind the UART RX FSM: edge-detected capture of 10-bit words
// into a first-word-fall-through FIFO with sticky overrun, framing-error count and level irq.
module is_uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [9:0]                 wr_data_i,
  input  logic                       rd_en_i,
  output logic [7:0]                 rd_data_o,
  output logic                       rd_par_o,
  output logic                       rd_ferr_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovr_o,
  input  logic                       ovr_clr_i,
  output logic [7:0]                 ferr_cnt_o,
  output logic                       irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          wr_en_p0;
  logic          ovr;
  logic          ovr_nxt;
  logic          irq_p0;
  logic [7:0]    ferr_cnt;
  logic [7:0]    ferr_nxt;
  logic          wr_evt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // A pop frees a slot in the same edge, so a write to a full FIFO survives when paired with a pop.
  always_comb begin
    wr_evt    = wr_en_i & ~wr_en_p0;
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    pop       = rd_en_i & ~empty;
    push      = wr_evt & (~full | pop);
    drop      = wr_evt & full & ~pop;
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
    ovr_nxt = ovr;
    if (drop) begin
      ovr_nxt = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_nxt = 1'b0;
    end
    ferr_nxt = ferr_cnt;
    if (push && wr_data_i[9] && (ferr_cnt != 8'hFF)) begin
      ferr_nxt = ferr_cnt + 8'd1;
    end
  end

  // ---- stage p0: control state, edge-detect copy and registered irq ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_p0 <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovr      <= 1'b0;
      ferr_cnt <= 8'd0;
      irq_p0   <= 1'b0;
    end else begin
      wr_en_p0 <= wr_en_i;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_nxt;
      ovr      <= ovr_nxt;
      ferr_cnt <= ferr_nxt;
      irq_p0   <= (count_nxt >= CW'(THRESH)) | ovr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem[rd_ptr][7:0];
  assign rd_par_o   = mem[rd_ptr][8];
  assign rd_ferr_o  = mem[rd_ptr][9];
  assign empty_o    = empty;
  assign full_o     = full;
  assign count_o    = count;
  assign ovr_o      = ovr;
  assign ferr_cnt_o = ferr_cnt;
  assign irq_o      = irq_p0;

endmodule

// File: tb/tb_is_uart_rx_fifo.sv
// Bench for is_uart_rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_is_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [9:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_par;
  logic       rd_ferr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovr;
  logic [7:0] ferr_cnt;
  logic       irq;

  is_uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_par_o(rd_par), .rd_ferr_o(rd_ferr), .empty_o(empty),
    .full_o(full), .count_o(count), .ovr_o(ovr), .ovr_clr_i(ovr_clr),
    .ferr_cnt_o(ferr_cnt), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words as a queue, flags as plain variables.
  logic [9:0] q[$];
  bit  m_prev = 1'b1;
  bit  m_ovr  = 1'b0;
  int  m_ferr = 0;
  bit  m_irq  = 1'b0;
  bit  check_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_prev = 1'b1;
      m_ovr  = 1'b0;
      m_ferr = 0;
      m_irq  = 1'b0;
    end else begin
      bit evt, do_pop, dropped;
      evt     = wr_en && !m_prev;
      do_pop  = rd_en && (q.size() > 0);
      dropped = evt && (q.size() == DEPTH) && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (evt && !dropped) begin
        q.push_back(wr_data);
        if (wr_data[9] && m_ferr < 255) m_ferr++;
      end
      if (dropped) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      m_irq  = (q.size() >= THRESH) || m_ovr;
      m_prev = wr_en;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("count", int'(count), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("ovr", int'(ovr), int'(m_ovr));
      chk("ferr_cnt", int'(ferr_cnt), m_ferr);
      chk("irq", int'(irq), int'(m_irq));
      if (q.size() > 0) begin
        chk("rd_data", int'(rd_data), int'(q[0][7:0]));
        chk("rd_par", int'(rd_par), int'(q[0][8]));
        chk("rd_ferr", int'(rd_ferr), int'(q[0][9]));
      end
    end
  end

  task automatic cyc(input bit w, input logic [9:0] d, input bit r, input bit c, input bit rs);
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; ovr_clr = c; rst = rs;
  endtask

  task automatic idle();
    cyc(0, 10'h0, 0, 0, 0);
  endtask

  task automatic wr(input logic [9:0] d);
    cyc(1, d, 0, 0, 0);
    idle();
  endtask

  initial begin
    // Reset with strobe already high: no write may follow release.
    cyc(1, 10'h155, 0, 0, 1);
    cyc(1, 10'h155, 0, 0, 1);
    check_en = 1'b1;
    cyc(1, 10'h155, 0, 0, 0);
    cyc(1, 10'h155, 0, 0, 0);
    idle();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_irq", int'(irq), 0);

    wr(10'h0A5);
    chk("single_count", int'(count), 1);
    chk("single_data", int'(rd_data), 8'hA5);
    chk("single_par", int'(rd_par), 0);
    chk("single_ferr", int'(rd_ferr), 0);
    cyc(0, 0, 1, 0, 0);
    idle();
    chk("pop_empty", int'(empty), 1);
    chk("pop_count", int'(count), 0);

    for (int i = 0; i < 5; i++) cyc(1, 10'h033, 0, 0, 0);
    idle();
    chk("held_count", int'(count), 1);
    cyc(0, 0, 1, 0, 0);
    idle();

    for (int i = 0; i < 16; i++) begin
      wr(10'(i));
      if (i == 6) chk("irq_before", int'(irq), 0);
      if (i == 7) chk("irq_at8", int'(irq), 1);
    end
    chk("full16", int'(full), 1);
    wr(10'h0FF);
    chk("ovr_count", int'(count), 16);
    chk("ovr_set", int'(ovr), 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("drain", int'(rd_data), i);
    end
    idle();
    chk("drained", int'(empty), 1);
    cyc(0, 0, 0, 1, 0);
    idle();
    chk("ovr_clr", int'(ovr), 0);

    for (int i = 0; i < 16; i++) wr(10'h040 + 10'(i));
    cyc(1, 10'h03C, 1, 0, 0);
    idle();
    chk("fullpop_count", int'(count), 16);
    chk("fullpop_ovr", int'(ovr), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("fullpop_drain", int'(rd_data), (i == 15) ? 8'h3C : 8'h41 + i);
    end
    idle();

    wr(10'h211); wr(10'h012); wr(10'h313); wr(10'h214);
    chk("ferr3", int'(ferr_cnt), 3);
    for (int i = 0; i < 12; i++) wr(10'h020 + 10'(i));
    cyc(1, 10'h0EE, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("ovr_prio", int'(ovr), 1);
    idle();
    chk("ovr_clr2", int'(ovr), 0);

    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, 1, 0, 0);
    end
    idle();
    chk("five", int'(count), 5);
    cyc(1, 10'h2AA, 1, 0, 1);
    idle();
    chk("mrst_count", int'(count), 0);
    chk("mrst_empty", int'(empty), 1);
    chk("mrst_ovr", int'(ovr), 0);
    chk("mrst_ferr", int'(ferr_cnt), 0);
    chk("mrst_irq", int'(irq), 0);

    for (int i = 0; i < 300; i++) begin
      cyc(1, 10'h200 | 10'(i & 8'hFF), 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    idle();
    chk("ferr_sat", int'(ferr_cnt), 255);

    for (int ph = 0; ph < 4; ph++) begin
      int rp;
      rp = (ph == 0) ? 10 : (ph == 1) ? 40 : (ph == 2) ? 75 : 25;
      for (int i = 0; i < 750; i++) begin
        cyc($urandom_range(0, 99) < 45, 10'($urandom), $urandom_range(0, 99) < rp,
            $urandom_range(0, 99) < 4, $urandom_range(0, 999) < 3);
      end
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/is_uart_rx_fifo.md
# is_uart_rx_fifo

Receive buffer sitting directly downstream of the UART receive FSM. It captures each completed 10-bit receive word on the FSM's one-cycle completion strobe. The word holds 8 data bits, the parity/space flag and the framing-error flag. Words are stored in a first-word-fall-through FIFO that the host/register side drains at its own pace. The block also keeps a sticky overrun flag, a saturating framing-error counter and a threshold interrupt.

## Interface
- DEPTH, 16: number of stored words; power of two, 2..256.
- THRESH, 8: interrupt level; irq_o asserts when count_o >= THRESH; valid range 1..DEPTH.
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset; synchronous and active-high (fixed).
- wr_en_i  in  1  receive-complete strobe from the RX FSM (rx_data_en_o).
- wr_data_i  in  10  receive word: [7:0] data, [8] parity/space flag, [9] framing-error flag.
- rd_en_i  in  1  host pop request; honoured only when empty_o=0.
- rd_data_o  out  8  head word data bits (fall-through).
- rd_par_o  out  1  head word bit 8.
- rd_ferr_o  out  1  head word bit 9.
- empty_o  out  1  FIFO holds no words.
- full_o  out  1  FIFO holds DEPTH words.
- count_o  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- ovr_o  out  1  sticky overrun: a word was dropped.
- ovr_clr_i  in  1  clears ovr_o.
- ferr_cnt_o  out  8  saturating count of accepted words with bit 9 set.
- irq_o  out  1  registered interrupt: (count_o >= THRESH) | ovr_o.

## Operation
- Write edge detect:
  - A write occurs only on a 0->1 transition of wr_en_i, using a registered copy of wr_en_i.
  - A strobe held high for several cycles produces exactly one write.
  - The registered copy resets to 1, so a strobe already high out of reset produces no write.
- Storage:
  - DEPTH x 10 register array with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - count_o is held in a separate register. full_o and empty_o are decoded from count_o.
- Write, not full: store wr_data_i at the write pointer, increment the write pointer, count +1.
- Write while full with no pop in the same cycle:
  - The word is dropped and the array and pointers are unchanged.
  - ovr_o is set on the next edge.
- Pop while not empty: increment the read pointer, count -1. A pop while empty is ignored, with no pointer or count change.
- Simultaneous write and pop:
  - Not empty (including full): both occur and count is unchanged. The write is not dropped when full.
  - Empty: only the write occurs and count becomes 1.
- rd_data_o, rd_par_o and rd_ferr_o are combinational from the array at the read pointer. Their value is don't-care while empty_o=1.
- ovr_o:
  - Set takes priority over ovr_clr_i in the same cycle.
  - Otherwise ovr_clr_i clears it.
- ferr_cnt_o increments for each accepted write with wr_data_i[9]=1 and saturates at 255. Dropped words are not counted.
- Reset values: pointers 0, count_o 0, empty_o 1, full_o 0, ovr_o 0, ferr_cnt_o 0, irq_o 0. Array contents are not reset.
- Reset asserted mid-operation discards all stored words on that edge.

## Timing
- Accepted write edge at cycle N (wr_en_i seen high in N, low in N-1):
  - count_o, empty_o and full_o update at the edge ending cycle N.
  - The head word is visible on rd_data_o in cycle N+1 if the FIFO was empty.
- Pop sampled in cycle N: the next head word appears in cycle N+1.
- irq_o is registered from next-state values and follows count_o/ovr_o changes with the same one-edge latency. It is not delayed further.
- No combinational path from wr_data_i to rd_data_o. An empty FIFO never shows the incoming word in the same cycle.
- A pop may be asserted every cycle. Back-to-back writes are limited only by the edge detect: at most one write every 2 cycles.

## Test plan
- Reset, then a single strobe with wr_data_i=10'h0A5 -> next cycle empty_o=0, count_o=1, rd_data_o=8'hA5, rd_par_o=0, rd_ferr_o=0. A pop then gives empty_o=1, count_o=0.
- wr_en_i held high 5 cycles with 10'h033 -> exactly one word stored, count_o=1.
- Write 16 words 8'h00..8'h0F (DEPTH=16):
  - irq_o asserts after the 8th write; full_o=1 after the 16th.
  - A 17th write of 8'hFF leaves count_o=16 and sets ovr_o=1.
  - Popping 16 words returns 8'h00..8'h0F in order with no 8'hFF.
- FIFO full and a write coincides with a pop -> count_o stays 16, ovr_o stays 0, and the new word appears last on drain.
- Write 3 words with bit 9 set and 1 without -> ferr_cnt_o=3. Assert ovr_clr_i in the same cycle an overrun occurs -> ovr_o=1. ovr_clr_i alone on the next cycle -> ovr_o=0.
- Fill to 5 words, assert rst_i for one cycle with a write and a pop pending -> count_o=0, empty_o=1, ovr_o=0, ferr_cnt_o=0, irq_o=0.
